// File: rtl/ram_arb.sv
// Two-requester block-transfer arbiter for the shared SDRAM port: picks an owner,
// issues the block command, routes the data stream and counts words to block end.
module ram_arb #(
  parameter int unsigned BlockIdxW    = 13,
  parameter int unsigned BlockWords   = 256,
  parameter int unsigned MaxImgStreak = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 img_req,
  input  logic [BlockIdxW-1:0] img_block,
  output logic                 img_gnt,
  input  logic                 img_wvalid,
  input  logic [15:0]          img_wdata,
  output logic                 img_wready,
  output logic                 img_done,
  input  logic                 rd_req,
  input  logic [BlockIdxW-1:0] rd_block,
  output logic                 rd_gnt,
  output logic                 rd_rvalid,
  output logic [15:0]          rd_rdata,
  input  logic                 rd_rready,
  output logic                 rd_done,
  output logic                 ctl_cmd_valid,
  input  logic                 ctl_cmd_ready,
  output logic                 ctl_cmd_write,
  output logic [BlockIdxW-1:0] ctl_cmd_block,
  output logic                 ctl_wvalid,
  input  logic                 ctl_wready,
  output logic [15:0]          ctl_wdata,
  input  logic                 ctl_rvalid,
  output logic                 ctl_rready,
  input  logic [15:0]          ctl_rdata
);

  localparam int unsigned CntW    = $clog2(BlockWords);
  localparam int unsigned StreakW = $clog2(MaxImgStreak + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [CntW-1:0]      count, count_nxt;
  logic [StreakW-1:0]   streak, streak_nxt;
  logic                 cmd_write_nxt;
  logic [BlockIdxW-1:0] cmd_block_nxt;
  logic                 img_gnt_nxt, rd_gnt_nxt;
  logic                 img_done_nxt, rd_done_nxt;
  logic                 cmd_valid_nxt;
  logic                 xfer_img_c, xfer_rd_c, hs_c, rd_wins_c;

  // Data passthrough, gated so the non-owner and the idle controller side see zeros
  assign xfer_img_c = (state == XFER) && ctl_cmd_write;
  assign xfer_rd_c  = (state == XFER) && !ctl_cmd_write;

  assign ctl_wvalid = xfer_img_c && img_wvalid;
  assign ctl_wdata  = xfer_img_c ? img_wdata : 16'd0;
  assign img_wready = xfer_img_c && ctl_wready;
  assign rd_rvalid  = xfer_rd_c && ctl_rvalid;
  assign rd_rdata   = xfer_rd_c ? ctl_rdata : 16'd0;
  assign ctl_rready = xfer_rd_c && rd_rready;

  assign hs_c      = xfer_img_c ? (img_wvalid && ctl_wready) : (xfer_rd_c && ctl_rvalid && rd_rready);
  assign rd_wins_c = rd_req && (!img_req || (streak == StreakW'(MaxImgStreak)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      streak        <= '0;
      ctl_cmd_write <= 1'b0;
      ctl_cmd_block <= '0;
      ctl_cmd_valid <= 1'b0;
      img_gnt       <= 1'b0;
      rd_gnt        <= 1'b0;
      img_done      <= 1'b0;
      rd_done       <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      streak        <= streak_nxt;
      ctl_cmd_write <= cmd_write_nxt;
      ctl_cmd_block <= cmd_block_nxt;
      ctl_cmd_valid <= cmd_valid_nxt;
      img_gnt       <= img_gnt_nxt;
      rd_gnt        <= rd_gnt_nxt;
      img_done      <= img_done_nxt;
      rd_done       <= rd_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    streak_nxt    = streak;
    cmd_write_nxt = ctl_cmd_write;
    cmd_block_nxt = ctl_cmd_block;
    cmd_valid_nxt = ctl_cmd_valid;
    img_gnt_nxt   = img_gnt;
    rd_gnt_nxt    = rd_gnt;
    img_done_nxt  = 1'b0;
    rd_done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (img_req || rd_req) begin
          state_nxt     = CMD;
          cmd_valid_nxt = 1'b1;
          if (rd_wins_c) begin
            cmd_write_nxt = 1'b0;
            cmd_block_nxt = rd_block;
            rd_gnt_nxt    = 1'b1;
            streak_nxt    = '0;
          end else begin
            cmd_write_nxt = 1'b1;
            cmd_block_nxt = img_block;
            img_gnt_nxt   = 1'b1;
            if (streak != StreakW'(MaxImgStreak)) streak_nxt = streak + StreakW'(1);
          end
        end
      end
      CMD: begin
        if (ctl_cmd_ready) begin
          state_nxt     = XFER;
          cmd_valid_nxt = 1'b0;
          count_nxt     = '0;
        end
      end
      XFER: begin
        if (hs_c) begin
          count_nxt = count + CntW'(1);
          if (count == CntW'(BlockWords - 1)) begin
            state_nxt    = DONE;
            img_done_nxt = ctl_cmd_write;
            rd_done_nxt  = !ctl_cmd_write;
          end
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        img_gnt_nxt = 1'b0;
        rd_gnt_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: a transaction-level ownership model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ram_arb;

  localparam int unsigned BW  = 256;
  localparam int unsigned IW  = 13;
  localparam int          MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          img_req, img_gnt, img_wvalid, img_wready, img_done;
  logic [IW-1:0] img_block, rd_block, ctl_cmd_block;
  logic [15:0]   img_wdata, rd_rdata, ctl_wdata, ctl_rdata;
  logic          rd_req, rd_gnt, rd_rvalid, rd_rready, rd_done;
  logic          ctl_cmd_valid, ctl_cmd_ready, ctl_cmd_write;
  logic          ctl_wvalid, ctl_wready, ctl_rvalid, ctl_rready;

  ram_arb #(.BlockIdxW(IW), .BlockWords(BW), .MaxImgStreak(MAX)) dut (
    .clk(clk), .rst(rst),
    .img_req(img_req), .img_block(img_block), .img_gnt(img_gnt),
    .img_wvalid(img_wvalid), .img_wdata(img_wdata), .img_wready(img_wready), .img_done(img_done),
    .rd_req(rd_req), .rd_block(rd_block), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_rready(rd_rready), .rd_done(rd_done),
    .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready),
    .ctl_cmd_write(ctl_cmd_write), .ctl_cmd_block(ctl_cmd_block),
    .ctl_wvalid(ctl_wvalid), .ctl_wready(ctl_wready), .ctl_wdata(ctl_wdata),
    .ctl_rvalid(ctl_rvalid), .ctl_rready(ctl_rready), .ctl_rdata(ctl_rdata)
  );

  always #5 clk = ~clk;

  int n_tests, n_fail;

  // Model: who owns the port, whether the command is still pending, words moved, done cycle
  int            m_owner;  // 0 none, 1 image, 2 readout
  bit            m_cmd, m_done;
  int            m_words, m_streak;
  logic [IW-1:0] m_block;

  bit   tog_rready;
  int   wr_hs, rd_hs, img_done_cnt, rd_done_cnt, done_total;
  logic prev_img_gnt, prev_rd_gnt;
  int   glog[$];
  int   exp_seq[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit xf, xi, xr, cmdv;
    xf   = (m_owner != 0) && !m_cmd && !m_done;
    xi   = xf && (m_owner == 1);
    xr   = xf && (m_owner == 2);
    cmdv = (m_owner != 0) && m_cmd;
    chk1("img_gnt", img_gnt, m_owner == 1);
    chk1("rd_gnt", rd_gnt, m_owner == 2);
    chk1("img_done", img_done, m_done && (m_owner == 1));
    chk1("rd_done", rd_done, m_done && (m_owner == 2));
    chk1("cmd_valid", ctl_cmd_valid, cmdv);
    if (cmdv) begin
      chk1("cmd_write", ctl_cmd_write, m_owner == 1);
      chkv("cmd_block", 32'(ctl_cmd_block), 32'(m_block));
    end
    chk1("ctl_wvalid", ctl_wvalid, xi && img_wvalid);
    chkv("ctl_wdata", 32'(ctl_wdata), xi ? 32'(img_wdata) : 32'd0);
    chk1("img_wready", img_wready, xi && ctl_wready);
    chk1("rd_rvalid", rd_rvalid, xr && ctl_rvalid);
    chkv("rd_rdata", 32'(rd_rdata), xr ? 32'(ctl_rdata) : 32'd0);
    chk1("ctl_rready", ctl_rready, xr && rd_rready);
    chk1("gnt_exclusive", img_gnt && rd_gnt, 1'b0);
    if ((img_gnt && !prev_img_gnt) || (rd_gnt && !prev_rd_gnt)) begin
      wr_hs = 0;
      rd_hs = 0;
      glog.push_back(img_gnt ? 1 : 2);
    end
    if (ctl_wvalid && ctl_wready) begin
      chkv("wr_order", 32'(ctl_wdata), 32'h0000A000 + 32'(wr_hs));
      wr_hs++;
    end
    if (rd_rvalid && rd_rready) begin
      chkv("rd_order", 32'(rd_rdata), 32'h00005000 + 32'(rd_hs));
      rd_hs++;
    end
    if (img_done) img_done_cnt++;
    if (rd_done) rd_done_cnt++;
    if (img_done || rd_done) done_total++;
    prev_img_gnt = img_gnt;
    prev_rd_gnt  = rd_gnt;
  endtask

  task automatic model_update();
    bit hs;
    if (rst) begin
      m_owner = 0; m_cmd = 0; m_done = 0; m_words = 0; m_streak = 0;
    end else if (m_done) begin
      m_done  = 0;
      m_owner = 0;
    end else if (m_owner == 0) begin
      if (rd_req && (!img_req || m_streak == MAX)) begin
        m_owner = 2; m_block = rd_block; m_streak = 0; m_cmd = 1;
      end else if (img_req) begin
        m_owner = 1; m_block = img_block; m_cmd = 1;
        if (m_streak < MAX) m_streak++;
      end
    end else if (m_cmd) begin
      if (ctl_cmd_ready) begin
        m_cmd   = 0;
        m_words = 0;
      end
    end else begin
      hs = (m_owner == 1) ? (img_wvalid && ctl_wready) : (ctl_rvalid && rd_rready);
      if (hs) begin
        m_words++;
        if (m_words == BW) m_done = 1;
      end
    end
  endtask

  // Source data carries its word index so ordering is visible at the sink
  task automatic drive_env();
    if (tog_rready) rd_rready = !rd_rready;
    img_wdata = 16'hA000 + 16'(m_words);
    ctl_rdata = 16'h5000 + 16'(m_words);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    drive_env();
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start = done_total;
    int n = 0;
    while (done_total == start && n < budget) begin
      step();
      n++;
    end
    chk1(nm, done_total != start, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    img_req = 1'b0; rd_req = 1'b0; img_block = '0; rd_block = '0;
    img_wvalid = 1'b1; img_wdata = 16'hA000; rd_rready = 1'b1;
    ctl_cmd_ready = 1'b1; ctl_wready = 1'b1; ctl_rvalid = 1'b1; ctl_rdata = 16'h5000;
    prev_img_gnt = 1'b0; prev_rd_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_img_gnt", img_gnt, 1'b0);
    chk1("rst_rd_gnt", rd_gnt, 1'b0);
    chk1("rst_cmd_valid", ctl_cmd_valid, 1'b0);
    chk1("rst_img_done", img_done, 1'b0);
    chk1("rst_rd_done", rd_done, 1'b0);
    chk1("rst_ctl_wvalid", ctl_wvalid, 1'b0);
    chk1("rst_ctl_rready", ctl_rready, 1'b0);
    chk1("rst_img_wready", img_wready, 1'b0);
    chk1("rst_rd_rvalid", rd_rvalid, 1'b0);
    rst = 1'b0;

    // Single image block, everything ready
    img_block = 13'h0ABC; img_req = 1'b1; img_done_cnt = 0;
    step();
    img_req = 1'b0;
    chk1("s1_gnt_latency", img_gnt, 1'b1);
    chk1("s1_cmd_valid", ctl_cmd_valid, 1'b1);
    chk1("s1_cmd_write", ctl_cmd_write, 1'b1);
    chkv("s1_cmd_block", 32'(ctl_cmd_block), 32'h0ABC);
    wait_done("s1_done_seen", 400);
    chkv("s1_words", 32'(wr_hs), 32'd256);
    chkv("s1_done_count", 32'(img_done_cnt), 32'd1);
    chk1("s1_gnt_low", img_gnt, 1'b0);

    // Single read block, sink ready every other cycle
    rd_block = 13'h0123; rd_req = 1'b1; rd_done_cnt = 0;
    step();
    rd_req = 1'b0;
    chk1("s2_rd_gnt", rd_gnt, 1'b1);
    chk1("s2_cmd_read", ctl_cmd_write, 1'b0);
    tog_rready = 1'b1;
    wait_done("s2_done_seen", 800);
    tog_rready = 1'b0; rd_rready = 1'b1;
    chkv("s2_words", 32'(rd_hs), 32'd256);
    step();
    chkv("s2_done_count", 32'(rd_done_cnt), 32'd1);

    // Both requesting continuously: image streak capped at four
    glog.delete();
    img_block = 13'h0100; rd_block = 13'h0200;
    img_req = 1'b1; rd_req = 1'b1;
    n = 0;
    while (glog.size() < 10 && n < 4000) begin
      step();
      n++;
    end
    img_req = 1'b0; rd_req = 1'b0;
    wait_done("s3_last_done", 600);
    chkv("s3_grant_count", 32'(glog.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < glog.size()) chkv("s3_grant_seq", 32'(glog[i]), 32'(exp_seq[i]));

    // Command held off for ten cycles
    ctl_cmd_ready = 1'b0; img_block = 13'h1555; img_req = 1'b1;
    step();
    img_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("s4_cmd_hold_valid", ctl_cmd_valid, 1'b1);
      chkv("s4_cmd_hold_block", 32'(ctl_cmd_block), 32'h1555);
      chkv("s4_no_early_data", 32'(wr_hs), 32'd0);
    end
    ctl_cmd_ready = 1'b1;
    wait_done("s4_done_seen", 400);
    chkv("s4_words", 32'(wr_hs), 32'd256);

    // Request dropped and block changed after grant
    ctl_cmd_ready = 1'b0; img_block = 13'h0777; img_req = 1'b1;
    step();
    img_req = 1'b0; img_block = 13'h1FFF;
    step();
    step();
    chkv("s5_block_hold", 32'(ctl_cmd_block), 32'h0777);
    ctl_cmd_ready = 1'b1;
    repeat (50) step();
    img_block = 13'h0AAA;
    wait_done("s5_done_seen", 400);
    chkv("s5_words", 32'(wr_hs), 32'd256);
    step();
    chk1("s5_no_regrant", img_gnt, 1'b0);

    // Reset in the middle of a read, then a clean read
    rd_block = 13'h0042; rd_req = 1'b1; rd_done_cnt = 0;
    step();
    rd_req = 1'b0;
    n = 0;
    while (!(m_owner == 2 && !m_cmd && m_words == 100) && n < 600) begin
      step();
      n++;
    end
    chkv("s6_reached_word100", 32'(rd_hs), 32'd100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("s6_rst_rd_gnt", rd_gnt, 1'b0);
    chk1("s6_rst_rd_rvalid", rd_rvalid, 1'b0);
    chk1("s6_rst_ctl_rready", ctl_rready, 1'b0);
    chk1("s6_rst_cmd_valid", ctl_cmd_valid, 1'b0);
    step();
    chkv("s6_no_done", 32'(rd_done_cnt), 32'd0);
    rd_block = 13'h0043; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk1("s6_regrant", rd_gnt, 1'b1);
    wait_done("s6_done_seen", 400);
    chkv("s6_words", 32'(rd_hs), 32'd256);
    chkv("s6_done_count", 32'(rd_done_cnt), 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
# ram_arb

Two-requester arbiter and sequencer for the shared SDRAM block-transfer port. The image writer (capture to RAM) and the readout reader (RAM to SD) each request whole-block transfers. The arbiter picks one owner, issues the block command to the RAM controller, routes the data stream between that owner and the controller, counts words, and releases ownership when the block ends. It sits inside the application top between the img/readout datapaths and the SDRAM controller.

## Interface
Parameters:
- BlockIdxW, 13: width of block index.
- BlockWords, 256: words per block transfer (≥2).
- MaxImgStreak, 4: consecutive image grants allowed while readout is waiting (≥1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- img_req  in  1  image writer requests a block write.
- img_block  in  BlockIdxW  target block; valid while img_req.
- img_gnt  out  1  image writer owns port.
- img_wvalid / img_wdata  in  1 / 16  write stream from image writer.
- img_wready  out  1  write accepted.
- img_done  out  1  one-cycle pulse at end of image block.
- rd_req  in  1  readout requests a block read.
- rd_block  in  BlockIdxW  source block.
- rd_gnt  out  1  readout owns port.
- rd_rvalid / rd_rdata  out  1 / 16  read stream to readout.
- rd_rready  in  1  readout accepts word.
- rd_done  out  1  one-cycle pulse at end of read block.
- ctl_cmd_valid  out  1; ctl_cmd_ready  in  1; ctl_cmd_write  out  1; ctl_cmd_block  out  BlockIdxW  block command to RAM controller.
- ctl_wvalid  out  1; ctl_wready  in  1; ctl_wdata  out  16  write data to controller.
- ctl_rvalid  in  1; ctl_rready  out  1; ctl_rdata  in  16  read data from controller.

## Operation
- States: IDLE, CMD, XFER, DONE.
- IDLE: when any req is high, choose the owner, latch direction and block into registers, set the matching gnt, and go to CMD.
  - Image wins by default.
  - Readout wins if rd_req && (!img_req || streak == MaxImgStreak).
- Streak counter:
  - Increments on each image grant and saturates at MaxImgStreak.
  - Clears on each readout grant.
- CMD: hold ctl_cmd_valid=1 with the latched write/block until ctl_cmd_ready. Go to XFER on the handshake cycle.
- XFER, image owner:
  - ctl_wvalid=img_wvalid, ctl_wdata=img_wdata, img_wready=ctl_wready.
  - Combinational passthrough, gated by state and owner.
- XFER, readout owner:
  - rd_rvalid=ctl_rvalid, rd_rdata=ctl_rdata, ctl_rready=rd_rready.
- Word counter, width $clog2(BlockWords):
  - Clears on entry to XFER.
  - Increments on each data handshake (valid&&ready on the active side).
  - A handshake while count==BlockWords-1 moves to DONE.
- DONE: pulse the owner's done for one cycle, drop gnt, return to IDLE.
- Non-owner side always sees wready/rvalid/gnt=0. Inactive ctl stream outputs are 0.
- Requests are sampled only in IDLE.
  - Dropping req after grant does not abort; the block always completes.
  - A req held high through DONE is re-arbitrated in IDLE on the next cycle.
- Block/direction registers are stable from grant to DONE; input changes are ignored.

## Timing
- Reset values: img_gnt=rd_gnt=0, img_done=rd_done=0, ctl_cmd_valid=0, ctl_wvalid=0, ctl_rready=0, img_wready=0, rd_rvalid=0. State=IDLE, streak=0, count=0.
- rst mid-transfer: all of the above are restored on the next edge with no done pulse. The RAM controller is reset by the same rst.
- Grant latency: req high in IDLE at edge N gives gnt=1 and ctl_cmd_valid=1 after edge N.
- Command: ctl_cmd_ready high at edge M puts the block in XFER after M. The first data handshake can occur in the same cycle.
- Data: zero added latency, full throughput (one word/cycle when both sides ready).
- End of block: the last handshake at edge K enters DONE after K. done=1 for one cycle and gnt still =1 that cycle. gnt falls after K+1. The earliest next grant is after K+2.
- Minimum per-block overhead: 3 cycles (IDLE, CMD, DONE) plus command wait.
- Simultaneous img_req and rd_req in IDLE: the priority rule above decides; only one gnt is ever high.

## Test plan
- Single image block, BlockWords=256, both sides always ready:
  - ctl_cmd_write=1, block passed through, exactly 256 ctl_wvalid&&ctl_wready handshakes.
  - img_done pulse one cycle after the 256th handshake; img_gnt low after.
- Single read block with rd_rready toggling every other cycle: 256 words delivered in order, matching ctl_rdata, and rd_done fires once.
- Both requesting continuously, MaxImgStreak=4: grant sequence img,img,img,img,rd,img,img,img,img,rd; never both gnt high.
- ctl_cmd_ready held low 10 cycles: ctl_cmd_valid and block stay stable, and no data handshake occurs before cmd acceptance.
- img_req dropped after grant and img_block changed mid-transfer: the transfer still completes 256 words to the original block.
- rst asserted at word 100 of a read: all outputs return to reset values next cycle with no rd_done, and a fresh rd_req afterwards completes normally.
